exception_controller: RTL and testbench

Parametrised successor to the combinational mode selector: latches NUM_SRC exception/interrupt requests into sticky pending bits and selects the highest-priority unmasked source. When interrupts are enabled, it transfers the processor from user to kernel mode, capturing the interrupted PC and the cause index. Kernel code returns with an rfe pulse. The block sits in the coprocessor, between the datapath exception sources (overflow, user input, future sources) and the control unit / PC mux.

---
 rtl/exception_controller.sv | 79 +++++++
 tb/tb_exception_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/exception_controller.sv
// Sticky exception pending latch with fixed-priority take into kernel mode.
// Latency: request -> pending at edge k, take (mode=1, exc_taken pulse) at edge k+1.
// No backpressure: requests are always absorbed into pending; rfe returns to user mode.
module exception_controller #(
   parameter int NUM_SRC = 4,
   parameter int CAUSE_W = 2,
   parameter int PC_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] src_req,
   input  logic [NUM_SRC-1:0] src_mask,
   input  logic               int_enable,
   input  logic [PC_W-1:0]    pc_in,
   input  logic               rfe,
   output logic               mode,
   output logic               exc_taken,
   output logic [CAUSE_W-1:0] cause,
   output logic [PC_W-1:0]    epc,
   output logic [NUM_SRC-1:0] pending
);

   typedef enum logic {USER = 1'b0, KERNEL = 1'b1} state_t;

   state_t             state;
   logic [NUM_SRC-1:0] avail;
   logic [NUM_SRC-1:0] firstHot;
   logic [NUM_SRC-1:0] clrMask;
   logic [CAUSE_W-1:0] selIdx;
   logic               found;
   logic               takeNow;

   // Lowest unmasked pending index wins; firstHot marks it for clearing.
   always_comb begin
      avail    = pending & ~src_mask;
      found    = 1'b0;
      selIdx   = '0;
      firstHot = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (avail[i] && !found) begin
            found       = 1'b1;
            selIdx      = CAUSE_W'(i);
            firstHot[i] = 1'b1;
         end
      end
      takeNow = (state == USER) && int_enable && found;
      clrMask = takeNow ? firstHot : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= USER;
         exc_taken <= 1'b0;
         cause     <= '0;
         epc       <= '0;
         pending   <= '0;
      end else begin
         // A new request on the clearing edge re-sets the bit.
         pending   <= (pending & ~clrMask) | src_req;
         exc_taken <= takeNow;
         case (state)
            USER: begin
               if (takeNow) begin
                  state <= KERNEL;
                  cause <= selIdx;
                  epc   <= pc_in;
               end
            end
            KERNEL: begin
               if (rfe) state <= USER;
            end
            default: state <= USER;
         endcase
      end
   end

   assign mode = (state == KERNEL);

endmodule

// File: tb/tb_exception_controller.sv
// Directed and randomized checks of exception_controller against a behavioural model.
module tb_exception_controller;

   localparam int NS = 4;

   logic          clk;
   logic          rst_n;
   logic [NS-1:0] src_req;
   logic [NS-1:0] src_mask;
   logic          int_enable;
   logic [15:0]   pc_in;
   logic          rfe;
   logic          mode;
   logic          exc_taken;
   logic [1:0]    cause;
   logic [15:0]   epc;
   logic [NS-1:0] pending;

   int nChecks = 0;
   int nFail   = 0;

   // Reference model state
   bit mPend[NS];
   bit mKernel;
   bit mExc;
   int mCause;
   int mEpc;

   exception_controller #(.NUM_SRC(NS), .CAUSE_W(2), .PC_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_mask(src_mask),
      .int_enable(int_enable), .pc_in(pc_in), .rfe(rfe), .mode(mode),
      .exc_taken(exc_taken), .cause(cause), .epc(epc), .pending(pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] modelPend();
      logic [31:0] v = '0;
      for (int i = 0; i < NS; i++) v[i] = mPend[i];
      return v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NS; i++) mPend[i] = 1'b0;
      mKernel = 1'b0;
      mExc    = 1'b0;
      mCause  = 0;
      mEpc    = 0;
   endtask

   // One clock edge: advance the model with the inputs present at the edge.
   task automatic modelEdge();
      int  pick = -1;
      bit  take;
      for (int i = NS - 1; i >= 0; i--)
         if (mPend[i] && !src_mask[i]) pick = i;
      take = !mKernel && int_enable && (pick >= 0);
      for (int i = 0; i < NS; i++)
         mPend[i] = (mPend[i] && !(take && i == pick)) || src_req[i];
      mExc = take;
      if (take) begin
         mKernel = 1'b1;
         mCause  = pick;
         mEpc    = int'(pc_in);
      end else if (mKernel && rfe) begin
         mKernel = 1'b0;
      end
   endtask

   task automatic checkAll(input string tag);
      chk({tag, ".mode"},    32'(mode),      32'(mKernel));
      chk({tag, ".exc"},     32'(exc_taken), 32'(mExc));
      chk({tag, ".cause"},   32'(cause),     32'(mCause));
      chk({tag, ".epc"},     32'(epc),       32'(mEpc));
      chk({tag, ".pending"}, 32'(pending),   modelPend());
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      if (rst_n) modelEdge();
      #1;
      checkAll(tag);
   endtask

   initial begin
      rst_n = 1'b0; src_req = 4'b1111; src_mask = '0; int_enable = 1'b0;
      pc_in = '0; rfe = 1'b0;
      modelReset();

      // Reset holds everything clear even with requests asserted
      cyc("rst");
      cyc("rst");
      chk("rst.mode", 32'(mode), 32'd0);
      chk("rst.pending", 32'(pending), 32'd0);
      rst_n = 1'b1;
      cyc("rel");
      chk("rel.pending", 32'(pending), 32'hF);

      // Clear pending by another reset
      rst_n = 1'b0; src_req = '0; #1; modelReset();
      cyc("rst2");
      rst_n = 1'b1;

      // Single take of source 1
      int_enable = 1'b1; pc_in = 16'h0040; src_req = 4'b0010;
      cyc("single0");
      src_req = '0;
      cyc("single1");
      chk("single.mode", 32'(mode), 32'd1);
      chk("single.cause", 32'(cause), 32'd1);
      chk("single.epc", 32'(epc), 32'h0040);
      chk("single.exc", 32'(exc_taken), 32'd1);
      chk("single.pending", 32'(pending), 32'd0);
      cyc("single2");
      chk("single.excpulse", 32'(exc_taken), 32'd0);
      rfe = 1'b1;
      cyc("single.rfe");
      rfe = 1'b0;

      // Priority with mask
      int_enable = 1'b0; src_mask = 4'b0010; src_req = 4'b1010;
      cyc("prio0");
      src_req = '0;
      chk("prio.pend", 32'(pending), 32'hA);
      int_enable = 1'b1;
      cyc("prio1");
      chk("prio.cause", 32'(cause), 32'd3);
      chk("prio.pendAfter", 32'(pending), 32'h2);
      src_mask = '0; rfe = 1'b1;
      cyc("prio.rfe");
      rfe = 1'b0;
      cyc("prio2");
      chk("prio.cause2", 32'(cause), 32'd1);

      // Return and re-entry
      src_req = 4'b0001;
      cyc("ret0");
      src_req = '0; rfe = 1'b1; pc_in = 16'h1234;
      cyc("ret.r");
      chk("ret.modeUser", 32'(mode), 32'd0);
      rfe = 1'b0; pc_in = 16'h2222;
      cyc("ret.r1");
      chk("ret.cause", 32'(cause), 32'd0);
      chk("ret.epc", 32'(epc), 32'h2222);
      rfe = 1'b1;
      cyc("ret.rfe");
      rfe = 1'b0;

      // Disabled: pending persists, no take
      int_enable = 1'b0; src_req = 4'b0100;
      cyc("dis0");
      src_req = '0;
      for (int i = 0; i < 5; i++) cyc("dis.hold");
      chk("dis.mode", 32'(mode), 32'd0);
      chk("dis.pending", 32'(pending), 32'h4);
      int_enable = 1'b1;
      cyc("dis.en");
      chk("dis.take", 32'(mode), 32'd1);
      rfe = 1'b1;
      cyc("dis.rfe");
      rfe = 1'b0;

      // Set wins over take-clear
      src_req = 4'b0100;
      cyc("sw0");
      cyc("sw1");
      chk("sw.pending2", 32'(pending[2]), 32'd1);
      chk("sw.mode", 32'(mode), 32'd1);
      src_req = '0;

      // Asynchronous reset mid-cycle in kernel mode
      #3;
      rst_n = 1'b0;
      #1;
      modelReset();
      chk("arst.mode", 32'(mode), 32'd0);
      chk("arst.pending", 32'(pending), 32'd0);
      cyc("arst.hold");
      rst_n = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         src_req    = 4'(($urandom_range(0, 3) == 0) ? $urandom : 0) & 4'($urandom);
         src_mask   = 4'($urandom) & 4'($urandom);
         int_enable = ($urandom_range(0, 7) != 0);
         rfe        = ($urandom_range(0, 3) == 0);
         pc_in      = 16'($urandom);
         cyc("rand");
      end

      $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
      $finish;
   end

endmodule
